dp_sequencer: RTL and testbench

Control sequencer for the SPARC-subset processor datapath. Drives the datapath's register enables, mux selects and memory handshake (MFA/MFC) through fetch, decode and execute for ALU, load, store and NOP-class instructions. Sits between the instruction register output and the datapath control inputs, replacing hand-driven control vectors. Flags illegal opcodes and memory timeouts by halting.

---
 rtl/dp_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dp_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_sequencer.sv
// Control sequencer for the SPARC-subset datapath: fetch, decode and execute of
// ALU, ld, st and NOP-class instructions with an MFA/MFC memory handshake.
module dp_sequencer #(
  parameter int unsigned MFC_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        MFC,
  output logic        ClrPC,
  output logic        IRE,
  output logic        MDRE,
  output logic        MARE,
  output logic        PCE,
  output logic        nPCE,
  output logic        RFE,
  output logic        MFA,
  output logic        MOP_SEL,
  output logic        MAR_SEL,
  output logic        MDR_SEL,
  output logic        RA_SEL,
  output logic [1:0]  RC_SEL,
  output logic [1:0]  ALU_SEL,
  output logic        AOP_SEL,
  output logic [3:0]  State,
  output logic        Halt,
  output logic        Illegal
);

  localparam int unsigned CW = (MFC_TIMEOUT < 1) ? 1 : $clog2(MFC_TIMEOUT + 1);

  localparam logic [3:0] S_RESET      = 4'd0;
  localparam logic [3:0] S_FETCH_ADDR = 4'd1;
  localparam logic [3:0] S_FETCH_WAIT = 4'd2;
  localparam logic [3:0] S_DECODE     = 4'd3;
  localparam logic [3:0] S_ALU_EXEC   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR   = 4'd5;
  localparam logic [3:0] S_LD_WAIT    = 4'd6;
  localparam logic [3:0] S_LD_WB      = 4'd7;
  localparam logic [3:0] S_ST_WAIT    = 4'd8;
  localparam logic [3:0] S_PC_UPDATE  = 4'd9;
  localparam logic [3:0] S_HALT       = 4'd15;

  logic [3:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          illegal_next;
  logic          timed_out;

  logic [1:0] op;
  logic [5:0] op3;
  logic       rd_zero, is_ld, is_st;
  logic       unused_ir;

  assign op        = IR[31:30];
  assign op3       = IR[24:19];
  assign rd_zero   = (IR[29:25] == 5'd0);
  assign is_ld     = (op3 == 6'b000000);
  assign is_st     = (op3 == 6'b000100);
  assign unused_ir = ^{IR[18:14], IR[12:0]};

  // Saturating wait counter; the increment that reaches the limit ends the wait.
  assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign timed_out = (cnt_inc >= CW'(MFC_TIMEOUT));

  assign State = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_RESET;
      cnt     <= '0;
      Illegal <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      Illegal <= illegal_next;
    end
  end

  // Next-state and Moore decode; IRE/MDRE additionally qualified by MFC in waits.
  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    illegal_next = Illegal;
    ClrPC   = 1'b0;
    IRE     = 1'b1;
    MDRE    = 1'b1;
    MARE    = 1'b1;
    PCE     = 1'b1;
    nPCE    = 1'b1;
    RFE     = 1'b1;
    MFA     = 1'b0;
    MOP_SEL = 1'b1;
    MAR_SEL = 1'b0;
    MDR_SEL = 1'b0;
    RA_SEL  = 1'b0;
    RC_SEL  = 2'd2;
    ALU_SEL = 2'd0;
    AOP_SEL = 1'b0;
    Halt    = 1'b0;

    case (state)
      S_RESET: begin
        ClrPC      = 1'b1;
        state_next = S_FETCH_ADDR;
      end
      S_FETCH_ADDR: begin
        MARE       = 1'b0;
        state_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        MFA     = 1'b1;
        MDR_SEL = 1'b1;
        if (MFC) begin
          IRE        = 1'b0;
          MDRE       = 1'b0;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_HALT;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_DECODE: begin
        if (op == 2'b10)                   state_next = S_ALU_EXEC;
        else if (op != 2'b11)              state_next = S_PC_UPDATE;
        else if (is_ld || is_st)           state_next = S_MEM_ADDR;
        else begin
          state_next   = S_HALT;
          illegal_next = 1'b1;
        end
      end
      S_ALU_EXEC: begin
        RA_SEL     = 1'b1;
        AOP_SEL    = IR[13];
        RC_SEL     = 2'd0;
        RFE        = rd_zero;
        state_next = S_PC_UPDATE;
      end
      S_MEM_ADDR: begin
        AOP_SEL = IR[13];
        MAR_SEL = 1'b1;
        MARE    = 1'b0;
        // A store also routes rd through the B path into MDR in this cycle.
        if (is_st) begin
          RA_SEL     = 1'b0;
          ALU_SEL    = 2'd2;
          MDRE       = 1'b0;
          state_next = S_ST_WAIT;
        end else begin
          RA_SEL     = 1'b1;
          ALU_SEL    = 2'd1;
          state_next = S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        MFA     = 1'b1;
        MDR_SEL = 1'b1;
        if (MFC) begin
          MDRE       = 1'b0;
          state_next = S_LD_WB;
        end else if (timed_out) begin
          state_next = S_HALT;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      S_LD_WB: begin
        RC_SEL     = 2'd1;
        ALU_SEL    = 2'd2;
        RFE        = rd_zero;
        state_next = S_PC_UPDATE;
      end
      S_ST_WAIT: begin
        MFA     = 1'b1;
        MOP_SEL = 1'b0;
        if (MFC)            state_next = S_PC_UPDATE;
        else if (timed_out) state_next = S_HALT;
        else                cnt_next   = cnt_inc;
      end
      S_PC_UPDATE: begin
        PCE        = 1'b0;
        nPCE       = 1'b0;
        state_next = S_FETCH_ADDR;
      end
      S_HALT: begin
        Halt = 1'b1;
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: per-cycle expected control vectors are queued
// as stimulus is applied and popped when the DUT outputs are sampled.
module tb_dp_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IR;
  logic        MFC;
  logic        ClrPC, IRE, MDRE, MARE, PCE, nPCE, RFE, MFA;
  logic        MOP_SEL, MAR_SEL, MDR_SEL, RA_SEL, AOP_SEL, Halt, Illegal;
  logic [1:0]  RC_SEL, ALU_SEL;
  logic [3:0]  State;

  typedef struct packed {
    logic [3:0] state;
    logic       clrpc, ire, mdre, mare, pce, npce, rfe, mfa;
    logic       mop, mar_sel, mdr_sel, ra_sel;
    logic [1:0] rc_sel, alu_sel;
    logic       aop, halt, illegal;
  } ctl_t;

  ctl_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  dp_sequencer #(.MFC_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .MFC(MFC),
    .ClrPC(ClrPC), .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE),
    .RFE(RFE), .MFA(MFA), .MOP_SEL(MOP_SEL), .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL),
    .RA_SEL(RA_SEL), .RC_SEL(RC_SEL), .ALU_SEL(ALU_SEL), .AOP_SEL(AOP_SEL),
    .State(State), .Halt(Halt), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  // Expected vectors per state, straight from the control table.
  function automatic ctl_t e_idle(input logic [3:0] s);
    ctl_t c;
    c = '0;
    c.state = s;
    {c.ire, c.mdre, c.mare, c.pce, c.npce, c.rfe} = 6'b111111;
    c.mop    = 1'b1;
    c.rc_sel = 2'd2;
    return c;
  endfunction

  function automatic ctl_t e_reset();
    ctl_t c = e_idle(4'd0);
    c.clrpc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_faddr();
    ctl_t c = e_idle(4'd1);
    c.mare = 1'b0;
    return c;
  endfunction

  function automatic ctl_t e_fwait(input logic mfc);
    ctl_t c = e_idle(4'd2);
    c.mfa = 1'b1; c.mdr_sel = 1'b1;
    c.ire = ~mfc; c.mdre = ~mfc;
    return c;
  endfunction

  function automatic ctl_t e_alu(input logic rfe, input logic aop);
    ctl_t c = e_idle(4'd4);
    c.ra_sel = 1'b1; c.aop = aop; c.rc_sel = 2'd0; c.rfe = rfe;
    return c;
  endfunction

  function automatic ctl_t e_maddr(input logic st, input logic aop);
    ctl_t c = e_idle(4'd5);
    c.aop = aop; c.mar_sel = 1'b1; c.mare = 1'b0;
    if (st) begin
      c.ra_sel = 1'b0; c.alu_sel = 2'd2; c.mdre = 1'b0;
    end else begin
      c.ra_sel = 1'b1; c.alu_sel = 2'd1;
    end
    return c;
  endfunction

  function automatic ctl_t e_ldwait(input logic mfc);
    ctl_t c = e_idle(4'd6);
    c.mfa = 1'b1; c.mdr_sel = 1'b1; c.mdre = ~mfc;
    return c;
  endfunction

  function automatic ctl_t e_ldwb(input logic rfe);
    ctl_t c = e_idle(4'd7);
    c.rc_sel = 2'd1; c.alu_sel = 2'd2; c.rfe = rfe;
    return c;
  endfunction

  function automatic ctl_t e_stwait();
    ctl_t c = e_idle(4'd8);
    c.mfa = 1'b1; c.mop = 1'b0;
    return c;
  endfunction

  function automatic ctl_t e_pcu();
    ctl_t c = e_idle(4'd9);
    c.pce = 1'b0; c.npce = 1'b0;
    return c;
  endfunction

  function automatic ctl_t e_halt(input logic ill);
    ctl_t c = e_idle(4'd15);
    c.halt = 1'b1; c.illegal = ill;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.state = State; c.clrpc = ClrPC; c.ire = IRE; c.mdre = MDRE; c.mare = MARE;
    c.pce = PCE; c.npce = nPCE; c.rfe = RFE; c.mfa = MFA; c.mop = MOP_SEL;
    c.mar_sel = MAR_SEL; c.mdr_sel = MDR_SEL; c.ra_sel = RA_SEL; c.rc_sel = RC_SEL;
    c.alu_sel = ALU_SEL; c.aop = AOP_SEL; c.halt = Halt; c.illegal = Illegal;
    return c;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs 1ns later.
  task automatic cyc(input logic rst, input logic mfc, input ctl_t exp, input string tag);
    ctl_t got, want;
    @(negedge Clk);
    Reset = rst;
    MFC   = mfc;
    sb.push_back(exp);
    #1;
    got  = sample();
    want = sb.pop_front();
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                tag, got.state, got, want.state, want);
  endtask

  // FETCH_ADDR, FETCH_WAIT with MFC after k cycles, then DECODE.
  task automatic fetch(input int k, input string tag);
    cyc(0, 0, e_faddr(), {tag, ":faddr"});
    for (int i = 0; i < k; i++) cyc(0, 0, e_fwait(1'b0), {tag, ":fwait"});
    cyc(0, 1, e_fwait(1'b1), {tag, ":fwait_mfc"});
    cyc(0, 0, e_idle(4'd3), {tag, ":decode"});
  endtask

  initial begin
    Reset = 1'b1;
    MFC   = 1'b0;
    IR    = 32'h0000_0000;
    repeat (2) @(posedge Clk);

    // Reset, then NOP with MFC one cycle after MFA
    cyc(0, 0, e_reset(), "reset");
    fetch(1, "nop");
    cyc(0, 0, e_pcu(), "nop:pcu");

    // add %g1,%g2,%g3
    IR = 32'h8600_4002;
    fetch(0, "alu");
    cyc(0, 0, e_alu(1'b0, 1'b0), "alu:exec");
    cyc(0, 0, e_pcu(), "alu:pcu");

    // ld [%g1+4],%g3 with data MFC after 3 cycles
    IR = 32'hC600_6004;
    fetch(0, "ld");
    cyc(0, 0, e_maddr(1'b0, 1'b1), "ld:maddr");
    for (int i = 0; i < 3; i++) cyc(0, 0, e_ldwait(1'b0), "ld:wait");
    cyc(0, 1, e_ldwait(1'b1), "ld:wait_mfc");
    cyc(0, 0, e_ldwb(1'b0), "ld:wb");
    cyc(0, 0, e_pcu(), "ld:pcu");

    // st %g3,[%g1+4] with data MFC after 1 cycle
    IR = 32'hC620_6004;
    fetch(0, "st");
    cyc(0, 0, e_maddr(1'b1, 1'b1), "st:maddr");
    cyc(0, 0, e_stwait(), "st:wait");
    cyc(0, 1, e_stwait(), "st:wait_mfc");
    cyc(0, 0, e_pcu(), "st:pcu");

    // ALU with rd = 0 must not write the register file
    IR = 32'h8000_4002;
    fetch(0, "alu_rd0");
    cyc(0, 0, e_alu(1'b1, 1'b0), "alu_rd0:exec");
    cyc(0, 0, e_pcu(), "alu_rd0:pcu");

    // Reset during the 3rd LD_WAIT cycle aborts the handshake
    IR = 32'hC600_6004;
    fetch(0, "ld_rst");
    cyc(0, 0, e_maddr(1'b0, 1'b1), "ld_rst:maddr");
    cyc(0, 0, e_ldwait(1'b0), "ld_rst:wait1");
    cyc(0, 0, e_ldwait(1'b0), "ld_rst:wait2");
    cyc(1, 0, e_ldwait(1'b0), "ld_rst:wait3");
    cyc(0, 1, e_reset(), "ld_rst:reset");

    // Illegal opcode halts; MFC toggling is ignored; Reset restarts
    IR = 32'hC668_6004;
    fetch(0, "ill");
    for (int i = 0; i < 20; i++) cyc(0, 1'(i % 2), e_halt(1'b1), "ill:halt");
    cyc(1, 0, e_halt(1'b1), "ill:halt_rst");
    cyc(0, 0, e_reset(), "ill:reset");

    // Fetch timeout: 16 wait cycles without MFC, then HALT without Illegal
    IR = 32'h0000_0000;
    cyc(0, 0, e_faddr(), "tmo:faddr");
    for (int i = 0; i < 16; i++) cyc(0, 0, e_fwait(1'b0), "tmo:fwait");
    cyc(0, 1, e_halt(1'b0), "tmo:halt");
    cyc(1, 0, e_halt(1'b0), "tmo:halt_rst");
    cyc(0, 0, e_reset(), "tmo:reset");
    cyc(0, 0, e_faddr(), "tmo:restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
